// File: rtl/rv_muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   m_op_e   : funct3 encodings of the eight M-extension operations
//   state_e  : sequencer states (IDLE, CALC, FIX)
//   helpers  : operand signedness and op-class decode from funct3
package rv_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Divide-class ops all have funct3[2] set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is signed for MUL/MULH/MULHSU and DIV/REM.
  function automatic logic op_a_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : (op[1:0] != 2'b11);
  endfunction

  // rs2 is signed for MUL/MULH and DIV/REM.
  function automatic logic op_b_signed(input logic [2:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction

endpackage

// File: rtl/rv_muldiv_seq_if.sv
// Request/response bundle between the stage-2 issue logic and the muldiv unit.
//   start/op/a/b/abort : request side, driven by the master
//   busy/done/r        : status and result, driven by the slave (the unit)
interface rv_muldiv_seq_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            abort;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] r;

  modport master (output start, op, a, b, abort, input busy, done, r);
  modport slave  (input start, op, a, b, abort, output busy, done, r);
endinterface

// File: rtl/rv_muldiv_seq_step.sv
// One combinational bit-step of the shared multiply/divide datapath.
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   m      : multiplicand (mul) or divisor magnitude (div)
//   hi_i/lo_i -> hi_o/lo_o : {upper, lower} halves of the 2*XLEN accumulator
// Multiply: add m into the upper half when the low bit is set, then shift right.
// Divide:   shift left, trial-subtract m from the partial remainder, keep it
//           when no borrow and shift the new quotient bit into the lower half.
module rv_muldiv_seq_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] m,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m} : '0);
    shifted = {hi_i, lo_i[XLEN-1]};
    // The partial remainder stays below m, so bit XLEN of the difference is
    // a clean borrow flag.
    diff    = shifted - {1'b0, m};
    if (is_div) begin
      hi_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end
endmodule

// File: rtl/rv_muldiv_seq.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : rv_muldiv_seq_if slave (start/op/a/b/abort in, busy/done/r out)
// Operands are reduced to magnitudes at accept; BPC bit-steps are retired per
// CALC cycle; FIX applies the sign and publishes r with a one-cycle done.
// Divide-by-zero and signed overflow skip CALC by preloading the accumulator
// with the architectural answer and zero sign flags.
module rv_muldiv_seq
  import rv_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input logic            clk,
  input logic            rst,
  rv_muldiv_seq_if.slave bus
);
  localparam int K  = XLEN / BPC;
  localparam int CW = $clog2(K + 1);

  state_e          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] hi_reg, lo_reg, m_reg, r_reg;
  logic            neg_reg, rneg_reg, busy_reg, done_reg;

  // Accept-time decode of the incoming request.
  logic            sa, sb, special, b_zero;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    sa      = op_a_signed(bus.op) & bus.a[XLEN-1];
    sb      = op_b_signed(bus.op) & bus.b[XLEN-1];
    a_mag   = sa ? -bus.a : bus.a;
    b_mag   = sb ? -bus.b : bus.b;
    b_zero  = (bus.b == '0);
    special = op_is_div(bus.op) &&
              (b_zero || (op_a_signed(bus.op) &&
                          bus.a == {1'b1, {(XLEN-1){1'b0}}} && bus.b == '1));
  end

  // Chain of BPC bit-steps fed from the accumulator registers.
  logic [XLEN-1:0] hi_c [BPC+1];
  logic [XLEN-1:0] lo_c [BPC+1];

  assign hi_c[0] = hi_reg;
  assign lo_c[0] = lo_reg;

  generate
    for (genvar gi = 0; gi < BPC; gi++) begin : g_step
      rv_muldiv_seq_step #(.XLEN(XLEN)) u_step (
        .is_div (op_reg[2]),
        .m      (m_reg),
        .hi_i   (hi_c[gi]),
        .lo_i   (lo_c[gi]),
        .hi_o   (hi_c[gi+1]),
        .lo_o   (lo_c[gi+1])
      );
    end
  endgenerate

  // Sign correction and result selection used in FIX.
  logic [2*XLEN-1:0] full_fix;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    full_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
    case (op_reg)
      M_MUL:                     fix_res = full_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: fix_res = full_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             fix_res = neg_reg ? -lo_reg : lo_reg;
      default:                   fix_res = rneg_reg ? -hi_reg : hi_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      m_reg     <= '0;
      r_reg     <= '0;
      neg_reg   <= 1'b0;
      rneg_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.abort) begin
        // Flush wins over everything, including a same-cycle start.
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.start) begin
              op_reg   <= bus.op;
              cnt_reg  <= CW'(K);
              busy_reg <= 1'b1;
              if (special) begin
                // Quotient lives in lo, remainder in hi, both unsigned.
                state_reg <= ST_FIX;
                neg_reg   <= 1'b0;
                rneg_reg  <= 1'b0;
                hi_reg    <= b_zero ? bus.a : '0;
                lo_reg    <= b_zero ? '1 : bus.a;
              end else begin
                state_reg <= ST_CALC;
                neg_reg   <= sa ^ sb;
                rneg_reg  <= sa;
                hi_reg    <= '0;
                lo_reg    <= op_is_div(bus.op) ? a_mag : b_mag;
                m_reg     <= op_is_div(bus.op) ? b_mag : a_mag;
              end
            end
          end
          ST_CALC: begin
            hi_reg  <= hi_c[BPC];
            lo_reg  <= lo_c[BPC];
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) state_reg <= ST_FIX;
          end
          ST_FIX: begin
            r_reg     <= fix_res;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.r    = r_reg;
endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Self-checking bench for rv_muldiv_seq: a BPC=1 and a BPC=4 instance share
// directed and random requests; results are compared against an arithmetic
// reference of the RV32M rules, plus latency, busy and handshake checks.
module tb_rv_muldiv_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv_muldiv_seq_if #(.XLEN(32)) if1 ();
  rv_muldiv_seq_if #(.XLEN(32)) if4 ();

  rv_muldiv_seq #(.XLEN(32), .BPC(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  rv_muldiv_seq #(.XLEN(32), .BPC(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_r1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa_l, sb_l, ua_l, ub_l, p;
    int ai, bi, qi;
    logic [31:0] res;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    ua_l = {32'b0, a};
    ub_l = {32'b0, b};
    ai = $signed(a);
    bi = $signed(b);
    res = '0;
    case (op)
      3'd0: begin p = ua_l * ub_l; res = p[31:0];  end
      3'd1: begin p = sa_l * sb_l; res = p[63:32]; end
      3'd2: begin p = sa_l * ub_l; res = p[63:32]; end
      3'd3: begin p = ua_l * ub_l; res = p[63:32]; end
      3'd4: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
        else begin qi = ai / bi; res = qi; end
      end
      3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h0;
        else begin qi = ai % bi; res = qi; end
      end
      default: res = (b == 0) ? a : a % b;
    endcase
    return res;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s1, input logic s4, input logic ab1,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if1.start = s1; if1.abort = ab1; if1.op = op; if1.a = a; if1.b = b;
    if4.start = s4; if4.abort = 1'b0; if4.op = op; if4.a = a; if4.b = b;
  endtask

  // Issue one op to both instances and watch a fixed 40-edge window.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat1, lat4, nd1, nd4, nb1, nb4, e1, e4;
    logic [31:0] exp, r1, r4;
    exp = ref_res(op, a, b);
    e1  = is_special(op, a, b) ? 1 : 33;
    e4  = is_special(op, a, b) ? 1 : 9;
    lat1 = -1; lat4 = -1; nd1 = 0; nd4 = 0; r1 = 'x; r4 = 'x;
    drive(1'b1, 1'b1, 1'b0, op, a, b);
    tick();
    nb1 = int'(if1.busy);
    nb4 = int'(if4.busy);
    drive(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (if1.done) begin nd1++; if (lat1 < 0) lat1 = n; r1 = if1.r; end
      if (if4.done) begin nd4++; if (lat4 < 0) lat4 = n; r4 = if4.r; end
      if (if1.busy) nb1++;
      if (if4.busy) nb4++;
      // Stray requests while dut1 is busy must be ignored.
      if (n < e1) begin
        if1.start = 1'($urandom_range(0, 1));
        if1.op = 3'($urandom_range(0, 7)); if1.a = $urandom; if1.b = $urandom;
      end else begin
        if1.start = 1'b0;
      end
    end
    check({tag, ".r1"}, r1, exp);
    check({tag, ".lat1"}, lat1, e1);
    check({tag, ".ndone1"}, nd1, 1);
    check({tag, ".busy1"}, nb1, e1);
    check({tag, ".hold1"}, if1.r, exp);
    check({tag, ".r4"}, r4, exp);
    check({tag, ".lat4"}, lat4, e4);
    check({tag, ".ndone4"}, nd4, 1);
    check({tag, ".busy4"}, nb4, e4);
    exp_r1 = exp;
    $display("op=%0d a=%h b=%h exp=%h r1=%h lat1=%0d r4=%h lat4=%0d [%s]",
             op, a, b, exp, r1, lat1, r4, lat4, tag);
  endtask

  initial begin
    int lat, nd;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset.busy1", if1.busy, 0);
    check("reset.done1", if1.done, 0);
    check("reset.r1", if1.r, 0);
    check("reset.busy4", if4.busy, 0);
    check("reset.r4", if4.r, 0);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu", 3'd5, 32'd100, 32'd7);
    run_op("remu", 3'd7, 32'd100, 32'd7);
    run_op("divu0", 3'd5, 32'd5, 32'd0);
    run_op("rem0", 3'd6, 32'd5, 32'd0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("rand", rop, ra, rb);
    end

    // start together with abort while idle: abort wins.
    drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd9, 32'd9);
    tick();
    check("abort_idle.busy1", if1.busy, 0);
    $display("abort+start in idle: busy1=%0d", if1.busy);

    // Abort in the 10th CALC cycle, with a same-cycle start that is dropped.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd6);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd5, 32'd6);
    repeat (9) tick();
    drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd9, 32'd9);
    tick();
    check("abort.busy1", if1.busy, 0);
    check("abort.done1", if1.done, 0);
    check("abort.r1", if1.r, exp_r1);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd3, 32'd4);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    lat = -1; nd = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (if1.done) begin nd++; if (lat < 0) lat = n; end
    end
    check("abort_mul.ndone", nd, 1);
    check("abort_mul.lat", lat, 33);
    check("abort_mul.r", if1.r, 32'd12);
    $display("abort then MUL 3*4: ndone=%0d lat=%0d r=%h", nd, lat, if1.r);

    // Back-to-back: new start in the done cycle is accepted.
    drive(1'b1, 1'b0, 1'b0, 3'd5, 32'd100, 32'd7);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd5, 32'd100, 32'd7);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (if1.done) begin lat = n; break; end
    end
    check("b2b.first_lat", lat, 33);
    check("b2b.first_r", if1.r, 32'd14);
    check("b2b.busy_in_done", if1.busy, 0);
    drive(1'b1, 1'b0, 1'b0, 3'd7, 32'd100, 32'd7);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    check("b2b.accepted", if1.busy, 1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (if1.done) begin lat = n; break; end
    end
    check("b2b.second_lat", lat, 33);
    check("b2b.second_r", if1.r, 32'd2);
    $display("back-to-back DIVU/REMU: lat=%0d r=%h", lat, if1.r);

    // Asynchronous reset in the middle of CALC.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd11, 32'd13);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("rst_mid.busy1", if1.busy, 0);
    check("rst_mid.r1", if1.r, 0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (if1.done) nd++;
    end
    check("rst_mid.ndone", nd, 0);
    $display("reset mid-CALC: ndone=%0d r=%h", nd, if1.r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
